// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// shift_pkg : shared state encoding and default word width for the shift path
// Revision  : 1.0
// ============================================================================
package shift_pkg;

  localparam int DEFAULT_DATA_BITS = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sipo_shift_reg.sv
`default_nettype none
// ============================================================================
// sipo_shift_reg : serial-in shift register, direction fixed by MSB_FIRST
// Revision       : 1.0
// ============================================================================
module sipo_shift_reg
  import shift_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 din,
  output logic [DATA_BITS-1:0] word_next
);

  logic [DATA_BITS-1:0] sr_q;
  logic [DATA_BITS-1:0] sr_d;
  logic [DATA_BITS-1:0] w_shift;

  // word_next is the register content after shifting in din, i.e. the
  // complete word when din is the final bit.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift = {sr_q[DATA_BITS-2:0], din};
    end else begin : g_lsb_first
      assign w_shift = {din, sr_q[DATA_BITS-1:1]};
    end
  endgenerate

  assign word_next = w_shift;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d = w_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ============================================================================
// shift_deserializer : serial stream to DATA_BITS words, one-entry valid/ready
//                      output register with sticky overflow on dropped words
// Revision           : 1.0
// ============================================================================
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_BITS = $clog2(DATA_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 sin_first,
  output logic [DATA_BITS-1:0] q,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  bit_cnt,
  output logic                 overflow
);

  localparam logic [CNT_BITS-1:0] C_LAST_CNT = CNT_BITS'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [DATA_BITS-1:0] q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 w_complete;
  logic [DATA_BITS-1:0] w_word;

  sipo_shift_reg #(
    .DATA_BITS (DATA_BITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (sin_valid),
    .din       (sin),
    .word_next (w_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    overflow_d = overflow_q;
    w_complete = 1'b0;

    if (sin_valid) begin
      unique case (state_q)
        IDLE: begin
          state_d = RECV;
          cnt_d   = CNT_BITS'(1);
        end
        RECV: begin
          if (sin_first) begin
            cnt_d = CNT_BITS'(1);
          end else if (cnt_q == C_LAST_CNT) begin
            w_complete = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (q_valid_q && q_ready) begin
      q_valid_d = 1'b0;
    end

    // A finished word may reuse the slot being drained in the same cycle.
    if (w_complete) begin
      if (!q_valid_q || q_ready) begin
        q_d       = w_word;
        q_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (clr) begin
      state_d    = IDLE;
      cnt_d      = '0;
      q_d        = '0;
      q_valid_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign busy     = (state_q == RECV);
  assign bit_cnt  = cnt_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_deserializer.sv
`default_nettype none
// ============================================================================
// tb_shift_deserializer : three DUT configurations driven by one stimulus
// Revision              : 1.0
// ============================================================================
module tb_shift_deserializer;

  logic clk = 1'b0;
  logic rst_n, clr, sin, sin_valid, sin_first, q_ready;

  logic [7:0]  q0, q1;
  logic [63:0] q2;
  logic        v0, v1, v2, b0, b1, b2, o0, o1, o2;
  logic [3:0]  c0, c1;
  logic [6:0]  c2;

  always #5 clk = ~clk;

  shift_deserializer #(.DATA_BITS(8), .MSB_FIRST(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .sin_first(sin_first), .q(q0), .q_valid(v0), .q_ready(q_ready),
    .busy(b0), .bit_cnt(c0), .overflow(o0));

  shift_deserializer #(.DATA_BITS(8), .MSB_FIRST(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .sin_first(sin_first), .q(q1), .q_valid(v1), .q_ready(q_ready),
    .busy(b1), .bit_cnt(c1), .overflow(o1));

  shift_deserializer #(.DATA_BITS(64), .MSB_FIRST(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .sin_first(sin_first), .q(q2), .q_valid(v2), .q_ready(q_ready),
    .busy(b2), .bit_cnt(c2), .overflow(o2));

  logic [63:0] dq[3];
  logic        dv[3], db[3], dov[3];
  logic [6:0]  dc[3];
  assign dq[0] = {56'b0, q0};
  assign dq[1] = {56'b0, q1};
  assign dq[2] = q2;
  assign dv[0] = v0;  assign dv[1] = v1;  assign dv[2] = v2;
  assign db[0] = b0;  assign db[1] = b1;  assign db[2] = b2;
  assign dov[0] = o0; assign dov[1] = o1; assign dov[2] = o2;
  assign dc[0] = {3'b0, c0};
  assign dc[1] = {3'b0, c1};
  assign dc[2] = c2;

  // Word-level model: each accepted bit is placed directly at its final
  // position in the word being assembled.
  int          nbits[3] = '{8, 8, 64};
  bit          msbf[3]  = '{1'b0, 1'b1, 1'b0};
  int          m_cnt[3];
  logic [63:0] m_acc[3];
  logic [63:0] m_q[3];
  bit          m_qv[3];
  bit          m_ov[3];

  int passes = 0;
  int total  = 0;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_acc[k] = '0; m_q[k] = '0; m_qv[k] = 1'b0; m_ov[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit          done;
      logic [63:0] word;
      int          pos;
      done = 1'b0;
      word = '0;
      if (!rst_n || clr) begin
        m_cnt[k] = 0; m_acc[k] = '0; m_q[k] = '0; m_qv[k] = 1'b0; m_ov[k] = 1'b0;
        continue;
      end
      if (sin_valid) begin
        if (sin_first || m_cnt[k] == 0) begin
          m_cnt[k] = 0;
          m_acc[k] = '0;
        end
        pos = msbf[k] ? (nbits[k] - 1 - m_cnt[k]) : m_cnt[k];
        m_acc[k][pos] = sin;
        m_cnt[k]++;
        if (m_cnt[k] == nbits[k]) begin
          done     = 1'b1;
          word     = m_acc[k];
          m_cnt[k] = 0;
        end
      end
      if (done) begin
        if (!m_qv[k] || q_ready) begin
          m_q[k]  = word;
          m_qv[k] = 1'b1;
        end else begin
          m_ov[k] = 1'b1;
        end
      end else if (m_qv[k] && q_ready) begin
        m_qv[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d.q", k),        dq[k],         m_q[k]);
      chk($sformatf("d%0d.q_valid", k),  64'(dv[k]),    64'(m_qv[k]));
      chk($sformatf("d%0d.overflow", k), 64'(dov[k]),   64'(m_ov[k]));
      chk($sformatf("d%0d.busy", k),     64'(db[k]),    64'(m_cnt[k] != 0));
      chk($sformatf("d%0d.bit_cnt", k),  64'(dc[k]),    64'(m_cnt[k]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [63:0] w, input int n, input bit first, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        sin_valid = 1'b0;
        sin_first = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      sin       = w[i];
      sin_valid = 1'b1;
      sin_first = first && (i == 0);
      tick();
    end
    sin_valid = 1'b0;
    sin_first = 1'b0;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; sin_first = 1'b0; q_ready = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    pulse_rst();

    // Bits 1,0,1,1,0,0,1,0: 8'h4D LSB-first, 8'hB2 MSB-first
    send_word(64'h4D, 8, 1'b0, 1'b0);
    chk("t1.q_lsb", dq[0], 64'h4D);
    chk("t1.q_msb", dq[1], 64'hB2);
    chk("t1.valid", 64'(dv[0]), 64'd1);
    chk("t1.busy",  64'(db[0]), 64'd0);

    clr = 1'b1; tick(); clr = 1'b0;
    send_word(64'h4D, 8, 1'b0, 1'b1);
    chk("t2.q_msb", dq[1], 64'hB2);
    chk("t2.cnt0",  64'(dc[1]), 64'd0);

    // Overflow with a stalled consumer, then drain
    clr = 1'b1; tick(); clr = 1'b0;
    send_word(64'h4D, 8, 1'b0, 1'b0);
    send_word(64'hB2, 8, 1'b0, 1'b0);
    chk("t3.q_held", dq[0], 64'h4D);
    chk("t3.ovf",    64'(dov[0]), 64'd1);
    q_ready = 1'b1; tick(); q_ready = 1'b0;
    chk("t3.drained", 64'(dv[0]), 64'd0);
    chk("t3.ovf_sticky", 64'(dov[0]), 64'd1);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3.ovf_clr", 64'(dov[0]), 64'd0);

    // Drain and reload in the same cycle
    send_word(64'h4D, 8, 1'b0, 1'b0);
    send_word(64'hB2, 7, 1'b0, 1'b0);
    sin = 1'b1; sin_valid = 1'b1; q_ready = 1'b1;
    tick();
    sin_valid = 1'b0; q_ready = 1'b0;
    chk("t4.q_new", dq[0], 64'hB2);
    chk("t4.valid", 64'(dv[0]), 64'd1);
    chk("t4.no_ovf", 64'(dov[0]), 64'd0);

    // Resync with sin_first, then reset mid-word
    q_ready = 1'b1; tick(); q_ready = 1'b0;
    send_word(64'h7, 3, 1'b0, 1'b0);
    send_word(64'hA5, 8, 1'b1, 1'b0);
    chk("t5.resync", dq[0], 64'hA5);
    q_ready = 1'b1; tick(); q_ready = 1'b0;
    send_word(64'h1F, 5, 1'b0, 1'b0);
    pulse_rst();
    chk("t5.no_valid", 64'(dv[0]), 64'd0);
    send_word(64'h3C, 8, 1'b0, 1'b0);
    chk("t5.clean", dq[0], 64'h3C);

    // Full-width 64-bit word
    clr = 1'b1; tick(); clr = 1'b0;
    q_ready = 1'b1;
    send_word(64'h0123_4567_89AB_CDEF, 64, 1'b0, 1'b0);
    q_ready = 1'b0;
    chk("t6.q64", dq[2], 64'h0123_4567_89AB_CDEF);
    chk("t6.ovf", 64'(dov[2]), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sin       = 1'($urandom);
      sin_valid = ($urandom_range(0, 3) != 0);
      sin_first = ($urandom_range(0, 19) == 0);
      q_ready   = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 149) == 0);
      tick();
    end
    sin_valid = 1'b0; sin_first = 1'b0; q_ready = 1'b0; clr = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
